fifo_word_unpacker: RTL

//  Read-side consumer for the RAM-based FIFO: pops WIDTH-bit words through the FIFO read port
//  (empty / shift_out / rdata) and emits each word as WIDTH/OUT_WIDTH narrower chunks on a

---
 rtl/fifo_word_unpacker.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fifo_word_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_word_unpacker
// Purpose  : Read-side consumer for a first-word-fall-through FIFO. Pops one
//            WIDTH-bit word at a time and emits it as WIDTH/OUT_WIDTH chunks
//            of OUT_WIDTH bits on a valid/ready stream. When the final chunk
//            of a word is accepted and another word is already waiting, the
//            next word is popped on that same edge, so output stays gap-free.
//            A 16-bit counter tracks completed words and wraps at 2^16.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH      FIFO word width (integer multiple of OUT_WIDTH)
//   OUT_WIDTH  output chunk width
//   MSB_FIRST  1: first chunk is word[WIDTH-1 -: OUT_WIDTH]
//              0: first chunk is word[OUT_WIDTH-1:0]
// Ports
//   clk             in   1          clock; all state changes on rising edge
//   res_n           in   1          synchronous active-low reset
//   fifo_empty      in   1          FIFO empty flag
//   fifo_rdata      in   WIDTH      FIFO head word (valid while !fifo_empty)
//   fifo_shift_out  out  1          pop strobe; FIFO advances on this edge
//   out_data        out  OUT_WIDTH  current chunk
//   out_valid       out  1          out_data valid
//   out_ready       in   1          sink accepts chunk when valid && ready
//   out_last        out  1          current chunk is last chunk of its word
//   busy            out  1          a word is loaded and being emitted
//   word_count      out  16         words whose last chunk was accepted
// ============================================================================
module fifo_word_unpacker #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_shift_out,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic [15:0]          word_count
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int N     = WIDTH / OUT_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [WIDTH-1:0]     r_word;        // shift register, head chunk at the output end
  logic [IDX_W-1:0]     r_idx;         // index of the chunk currently presented
  logic [15:0]          r_word_count;

  logic [WIDTH-1:0]     w_word_shifted;
  logic [OUT_WIDTH-1:0] w_head_chunk;
  logic                 w_accept;
  logic                 w_last_chunk;
  logic                 w_word_done;
  logic                 w_pop;
  logic                 w_advance;

  // --------------------------------------------------------------------------
  // Chunk extraction. The word is shifted towards the output end on every
  // non-final accept, so the presented chunk is always a fixed slice and no
  // wide index multiplexer is needed.
  // --------------------------------------------------------------------------
  generate
    if (N == 1) begin : g_single
      // One chunk per word: nothing ever shifts.
      assign w_word_shifted = r_word;
      assign w_head_chunk   = r_word;
    end else if (MSB_FIRST) begin : g_msb_first
      assign w_word_shifted = {r_word[WIDTH-OUT_WIDTH-1:0], {OUT_WIDTH{1'b0}}};
      assign w_head_chunk   = r_word[WIDTH-1 -: OUT_WIDTH];
    end else begin : g_lsb_first
      assign w_word_shifted = {{OUT_WIDTH{1'b0}}, r_word[WIDTH-1:OUT_WIDTH]};
      assign w_head_chunk   = r_word[OUT_WIDTH-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state and control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    w_accept     = (r_state == S_EMIT) && out_ready;
    w_last_chunk = (r_idx == LAST_IDX);
    w_word_done  = w_accept && w_last_chunk;

    case (r_state)
      S_IDLE: begin
        if (!fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EMIT;
        end
      end

      S_EMIT: begin
        if (w_accept) begin
          if (!w_last_chunk) begin
            w_advance = 1'b1;
          end else if (!fifo_empty) begin
            // Chain straight into the next word without a bubble cycle.
            w_pop = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The pop strobe is masked while reset is asserted: the FSM is being forced
  // to IDLE and any word taken now would be lost.
  assign fifo_shift_out = w_pop && res_n;

  // --------------------------------------------------------------------------
  // State register and datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!res_n) begin
      r_state      <= S_IDLE;
      r_word       <= '0;
      r_idx        <= '0;
      r_word_count <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_pop) begin
        r_word <= fifo_rdata;
        r_idx  <= '0;
      end else if (w_advance) begin
        r_word <= w_word_shifted;
        r_idx  <= r_idx + IDX_ONE;
      end

      // Natural 16-bit wrap from FFFF to 0000.
      if (w_word_done) begin
        r_word_count <= r_word_count + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. The stream outputs come straight from registers; data and last
  // are forced low in IDLE so a stale word is never visible.
  // --------------------------------------------------------------------------
  assign out_valid  = (r_state == S_EMIT);
  assign out_data   = out_valid ? w_head_chunk : '0;
  assign out_last   = out_valid && w_last_chunk;
  assign busy       = out_valid;
  assign word_count = r_word_count;

endmodule
`default_nettype wire
